// File: rtl/arc4_pkg.sv
// Shared crack-datapath definitions: printable-ASCII bounds and the pt_validate FSM state type.
package arc4_pkg;

    localparam logic [7:0] ASCII_LO = 8'h20;
    localparam logic [7:0] ASCII_HI = 8'h7E;

    typedef enum logic [2:0] {
        PTV_IDLE,
        PTV_FETCH_LEN,
        PTV_WAIT_LEN,
        PTV_SCAN,
        PTV_FIN
    } ptv_state_t;

endpackage

// File: rtl/pt_validate_if.sv
// Controller/pt_memory <-> pt_validate bundle. Optional bad_idx under PTV_FIRST_BAD_EN.
// Handshake: a request is accepted on a clock edge where en=1 and rdy=1; en while rdy=0 is
// ignored. done is a one-cycle pulse in which ok (and bad_idx) are valid, and rdy is high again.
interface pt_validate_if #(parameter int ADDR_W = 8);
    logic              en;
    logic              rdy;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        rddata;
    logic              done;
    logic              ok;
`ifdef PTV_FIRST_BAD_EN
    logic [ADDR_W-1:0] bad_idx;

    modport master (output en, rddata, input rdy, addr, done, ok, bad_idx);
    modport slave  (input en, rddata, output rdy, addr, done, ok, bad_idx);
`else
    modport master (output en, rddata, input rdy, addr, done, ok);
    modport slave  (input en, rddata, output rdy, addr, done, ok);
`endif
endinterface

// File: rtl/ascii_range_chk.sv
// Combinational unsigned range test LO <= b <= HI; shared with the crack top.
module ascii_range_chk #(
    parameter logic [7:0] LO = 8'h20,
    parameter logic [7:0] HI = 8'h7E
) (
    input  logic [7:0] b,
    output logic       pass
);
    assign pass = (b >= LO) && (b <= HI);
endmodule

// File: rtl/pt_validate.sv
// Scans a length-prefixed plaintext buffer and reports whether all text bytes are printable.
// Optional macro PTV_FIRST_BAD_EN adds the first-failing-index register/port (bad_idx).
module pt_validate
    import arc4_pkg::*;
#(
    parameter int         ADDR_W = 8,
    parameter logic [7:0] LO     = ASCII_LO,
    parameter logic [7:0] HI     = ASCII_HI
) (
    input  logic         clk,
    input  logic         rst,
    pt_validate_if.slave bus,
    output ptv_state_t   state_dbg
);
    localparam logic [ADDR_W-1:0] ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    ptv_state_t        state;
    logic              rdy_q, done_q, ok_q;
    logic [ADDR_W-1:0] addr_q, len_q, idx_q;
    logic [ADDR_W-1:0] len_in;
    logic              pass;
`ifdef PTV_FIRST_BAD_EN
    logic [ADDR_W-1:0] bad_q;
`endif

    assign len_in = ADDR_W'(bus.rddata);

    ascii_range_chk #(.LO(LO), .HI(HI)) u_chk (
        .b    (bus.rddata),
        .pass (pass)
    );

    // idx_q names the byte whose data is on rddata; addr_q runs one ahead and stops at L
    // so a full 255-byte buffer never wraps the address.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= PTV_IDLE;
            rdy_q  <= 1'b1;
            done_q <= 1'b0;
            ok_q   <= 1'b0;
            addr_q <= '0;
            len_q  <= '0;
            idx_q  <= '0;
`ifdef PTV_FIRST_BAD_EN
            bad_q  <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            unique case (state)
                PTV_IDLE, PTV_FIN: begin
                    if (bus.en) begin
                        state  <= PTV_FETCH_LEN;
                        rdy_q  <= 1'b0;
                        ok_q   <= 1'b0;
                        addr_q <= '0;
`ifdef PTV_FIRST_BAD_EN
                        bad_q  <= '0;
`endif
                    end else begin
                        state <= PTV_IDLE;
                    end
                end
                PTV_FETCH_LEN: begin
                    addr_q <= ONE;
                    state  <= PTV_WAIT_LEN;
                end
                PTV_WAIT_LEN: begin
                    len_q <= len_in;
                    idx_q <= ONE;
                    if (bus.rddata == 8'd0) begin
                        state  <= PTV_FIN;
                        done_q <= 1'b1;
                        rdy_q  <= 1'b1;
                        ok_q   <= 1'b1;
                    end else begin
                        state <= PTV_SCAN;
                        if (addr_q < len_in) addr_q <= addr_q + ONE;
                    end
                end
                PTV_SCAN: begin
                    if (!pass) begin
                        state  <= PTV_FIN;
                        done_q <= 1'b1;
                        rdy_q  <= 1'b1;
                        ok_q   <= 1'b0;
`ifdef PTV_FIRST_BAD_EN
                        bad_q  <= idx_q;
`endif
                    end else if (idx_q == len_q) begin
                        state  <= PTV_FIN;
                        done_q <= 1'b1;
                        rdy_q  <= 1'b1;
                        ok_q   <= 1'b1;
                    end else begin
                        idx_q <= idx_q + ONE;
                        if (addr_q < len_q) addr_q <= addr_q + ONE;
                    end
                end
                default: state <= PTV_IDLE;
            endcase
        end
    end

    assign bus.rdy   = rdy_q;
    assign bus.done  = done_q;
    assign bus.ok    = ok_q;
    assign bus.addr  = addr_q;
    assign state_dbg = state;
`ifdef PTV_FIRST_BAD_EN
    assign bus.bad_idx = bad_q;
`endif

endmodule
